btb_sa: RTL and testbench
=========================

BTB_SA -- requirements
Module: btb_sa

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, key/target width.
REQ-002 SHALL have parameter SETS, default 16, set count (power of 2, >=2); IDX_W = log2(SETS).
REQ-003 SHALL have parameter WAYS, default 2, associativity (1..8).
REQ-004 SHALL have parameter CTR_W, default 2, saturating prediction counter width (>=1).
REQ-005 SHALL have ports:
  clk  in  1  clock, all state on rising edge;
  reset  in  1  synchronous, active-high;
  read_en  in  1  lookup strobe (qualifies stats only);
  read_key  in  ADDR_W  fetch PC;
  read_val  out  ADDR_W  predicted target;
  read_hit  out  1  key present in a valid way;
  read_valid  out  1  hit and counter MSB=1 (predict taken);
  write  in  1  resolve/update strobe;
  write_key  in  ADDR_W  resolved branch PC;
  write_val  in  ADDR_W  resolved target;
  hit  in  1  branch resolved taken;
  flush  in  1  invalidate-all request pulse;
  busy  out  1  flush in progress;
  lookup_cnt  out  32  lookup statistic;
  hit_cnt  out  32  predicted-taken statistic.

Function
REQ-006 SHALL index sets by key[IDX_W+1:2]; each way stores valid bit, full ADDR_W key, ADDR_W target, CTR_W counter.
REQ-007 SHALL compute read_hit/read_valid/read_val combinationally from read_key in the same cycle; read_val = 0 when read_hit=0.
REQ-008 SHALL force read_hit=0 and read_valid=0 while busy=1.
REQ-009 SHALL, on write with matching valid way: overwrite target, counter +1 saturating at 2^CTR_W-1 if hit=1, else -1 saturating at 0.
REQ-010 SHALL, on write without match: allocate lowest-index invalid way in set; if none, the way at the set's round-robin pointer; allocation SHALL advance that pointer (mod WAYS) only when evicting a valid way.
REQ-011 SHALL initialise allocated counter to all-ones if hit=1, all-zeros if hit=0.
REQ-012 SHALL, on same-cycle read and write to the same key, return pre-write contents; update visible next cycle.
REQ-013 SHALL never hold two valid ways with equal key in one set.
REQ-014 SHALL implement FSM IDLE/FLUSH: IDLE + flush -> FLUSH, set cursor 0; FLUSH clears all valid bits of set[cursor] and resets its pointer each cycle; after cursor = SETS-1 -> IDLE.
REQ-015 SHALL assert busy exactly SETS cycles, starting the cycle after flush is sampled.
REQ-016 SHALL ignore write while busy=1 or when write and flush are sampled in the same IDLE cycle (flush wins).
REQ-017 SHALL ignore flush while busy=1.

Reset
REQ-018 SHALL, on reset, clear all valid bits, counters, pointers, flush cursor, lookup_cnt, hit_cnt, and enter IDLE in one cycle; busy=0, read_hit=0, read_valid=0, read_val=0 after reset.
REQ-019 SHALL let reset abort an in-progress flush and take priority over write and flush.

Configuration
REQ-020 SHALL, with BTB_STATS_EN defined, increment lookup_cnt on each cycle read_en=1 and busy=0, and hit_cnt when additionally read_valid=1; both saturate at 0xFFFFFFFF and clear on reset and on flush acceptance.
REQ-021 SHALL, without BTB_STATS_EN, tie lookup_cnt and hit_cnt to 0 and instantiate no counter logic.

Verification (SETS=16, WAYS=2, CTR_W=2)
REQ-022 SHALL cover: reset, read_key=0x40 -> read_hit=0, read_valid=0, read_val=0.
REQ-023 SHALL cover: write key 0x100 val 0x200 hit=1; next cycle read 0x100 -> read_hit=1, read_valid=1, read_val=0x200.
REQ-024 SHALL cover: two writes key 0x100 hit=0 -> counter 3->2->1; read_valid 1 after first, 0 after second, read_hit stays 1.
REQ-025 SHALL cover: allocate 0x100, 0x140, 0x180 (all set 0) hit=1 -> 0x180 evicts way0; read 0x100 read_hit=0, 0x140 and 0x180 read_hit=1.
REQ-026 SHALL cover: flush pulse with write key 0x300 one cycle later -> busy=1 for 16 cycles, 0x300 not allocated, all prior keys read_hit=0 afterwards.
REQ-027 SHALL cover: BTB_STATS_EN defined, 5 read_en lookups of which 2 predicted taken -> lookup_cnt=5, hit_cnt=2; undefined -> both 0.

Source files
------------

// File: rtl/btb_sa.sv
`default_nettype none
// ============================================================================
//  Module      : btb_sa
//  Description : Set-associative branch target buffer. Combinational lookup,
//                saturating taken/not-taken counters, round-robin eviction,
//                and a multi-cycle invalidate-all walk (one set per cycle).
//  Options     : define BTB_STATS_EN to build the lookup/taken statistics
//                counters; otherwise lookup_cnt/hit_cnt are tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module btb_sa #(
  parameter int ADDR_W = 32,
  parameter int SETS   = 16,
  parameter int WAYS   = 2,
  parameter int CTR_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] read_key,
  output logic [ADDR_W-1:0] read_val,
  output logic              read_hit,
  output logic              read_valid,
  input  logic              write,
  input  logic [ADDR_W-1:0] write_key,
  input  logic [ADDR_W-1:0] write_val,
  input  logic              hit,
  input  logic              flush,
  output logic              busy,
  output logic [31:0]       lookup_cnt,
  output logic [31:0]       hit_cnt
);

  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CTR_W-1:0] C_CTR_MAX = '1;
  localparam logic [WAY_W-1:0] C_LAST_WAY = WAY_W'(WAYS - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cursor_q, cursor_d;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [ADDR_W-1:0] key_q   [SETS][WAYS];
  logic [ADDR_W-1:0] val_q   [SETS][WAYS];
  logic [CTR_W-1:0]  ctr_q   [SETS][WAYS];
  logic [WAY_W-1:0]  rr_q    [SETS];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic             rd_match;
  logic [WAY_W-1:0] rd_way;
  logic             wr_match, wr_free;
  logic [WAY_W-1:0] wr_mway, wr_fway, wr_way;
  logic [CTR_W-1:0] ctr_cur, ctr_new;
  logic [WAY_W-1:0] rr_cur, rr_next;
  logic             flush_acc, wr_acc;

  assign rd_idx    = read_key[IDX_W+1:2];
  assign wr_idx    = write_key[IDX_W+1:2];
  assign busy      = (state_q == S_FLUSH);
  assign flush_acc = flush && (state_q == S_IDLE);
  // A flush sampled together with a write wins; writes are dropped while busy.
  assign wr_acc    = write && (state_q == S_IDLE) && !flush;

  // Lookup: find the (unique) valid way whose full key matches read_key.
  always_comb begin
    rd_match = 1'b0;
    rd_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!rd_match && valid_q[rd_idx][w] && (key_q[rd_idx][w] == read_key)) begin
        rd_match = 1'b1;
        rd_way   = WAY_W'(w);
      end
    end
  end

  assign read_hit   = rd_match && !busy;
  assign read_valid = read_hit && ctr_q[rd_idx][rd_way][CTR_W-1];
  assign read_val   = read_hit ? val_q[rd_idx][rd_way] : '0;

  // Update way selection: matching way, else lowest free way, else victim.
  always_comb begin
    wr_match = 1'b0;
    wr_mway  = '0;
    wr_free  = 1'b0;
    wr_fway  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!wr_match && valid_q[wr_idx][w] && (key_q[wr_idx][w] == write_key)) begin
        wr_match = 1'b1;
        wr_mway  = WAY_W'(w);
      end
      if (!wr_free && !valid_q[wr_idx][w]) begin
        wr_free = 1'b1;
        wr_fway = WAY_W'(w);
      end
    end
    rr_cur  = rr_q[wr_idx];
    rr_next = (rr_cur == C_LAST_WAY) ? '0 : rr_cur + 1'b1;
    if (wr_match)     wr_way = wr_mway;
    else if (wr_free) wr_way = wr_fway;
    else              wr_way = rr_cur;
  end

  // Counter: saturating step on a hit update, fresh strong value on allocate.
  always_comb begin
    ctr_cur = ctr_q[wr_idx][wr_way];
    ctr_new = ctr_cur;
    if (!wr_match)             ctr_new = hit ? C_CTR_MAX : '0;
    else if (hit)              ctr_new = (ctr_cur == C_CTR_MAX) ? ctr_cur : ctr_cur + 1'b1;
    else if (ctr_cur != '0)    ctr_new = ctr_cur - 1'b1;
  end

  // Flush FSM next state: walk the cursor over every set once.
  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          state_d  = S_FLUSH;
          cursor_d = '0;
        end
      end
      S_FLUSH: begin
        if (cursor_q == IDX_W'(SETS - 1)) state_d = S_IDLE;
        else                              cursor_d = cursor_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Flush FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cursor_q <= '0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
    end
  end

  // Control state: valid bits, counters and round-robin pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
        for (int w = 0; w < WAYS; w++) ctr_q[s][w] <= '0;
      end
    end else if (busy) begin
      valid_q[cursor_q] <= '0;
      rr_q[cursor_q]    <= '0;
    end else if (wr_acc) begin
      valid_q[wr_idx][wr_way] <= 1'b1;
      ctr_q[wr_idx][wr_way]   <= ctr_new;
      if (!wr_match && !wr_free) rr_q[wr_idx] <= rr_next;
    end
  end

  // Payload: key and target need no reset since valid bits gate them.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      key_q[wr_idx][wr_way] <= write_key;
      val_q[wr_idx][wr_way] <= write_val;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] lookup_cnt_q, hit_cnt_q;

  // Saturating lookup / predicted-taken statistics, cleared by a new flush.
  always_ff @(posedge clk) begin
    if (reset || flush_acc) begin
      lookup_cnt_q <= '0;
      hit_cnt_q    <= '0;
    end else if (read_en && !busy) begin
      if (lookup_cnt_q != '1)             lookup_cnt_q <= lookup_cnt_q + 1'b1;
      if (read_valid && hit_cnt_q != '1)  hit_cnt_q    <= hit_cnt_q + 1'b1;
    end
  end

  assign lookup_cnt = lookup_cnt_q;
  assign hit_cnt    = hit_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = read_en ^ flush_acc;
  assign lookup_cnt   = '0;
  assign hit_cnt      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_btb_sa.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btb_sa
//  Description : Self-checking bench for btb_sa: directed scenarios plus a
//                randomized stream compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btb_sa;

  localparam int ADDR_W = 32;
  localparam int SETS   = 16;
  localparam int WAYS   = 2;
  localparam int CTR_W  = 2;
  localparam int CMAX   = (1 << CTR_W) - 1;
  localparam longint SAT32 = 64'hFFFF_FFFF;

  logic              clk;
  logic              reset;
  logic              read_en;
  logic [ADDR_W-1:0] read_key;
  logic [ADDR_W-1:0] read_val;
  logic              read_hit;
  logic              read_valid;
  logic              write;
  logic [ADDR_W-1:0] write_key;
  logic [ADDR_W-1:0] write_val;
  logic              hit;
  logic              flush;
  logic              busy;
  logic [31:0]       lookup_cnt;
  logic [31:0]       hit_cnt;

  btb_sa #(.ADDR_W(ADDR_W), .SETS(SETS), .WAYS(WAYS), .CTR_W(CTR_W)) dut (
    .clk(clk), .reset(reset), .read_en(read_en), .read_key(read_key),
    .read_val(read_val), .read_hit(read_hit), .read_valid(read_valid),
    .write(write), .write_key(write_key), .write_val(write_val), .hit(hit),
    .flush(flush), .busy(busy), .lookup_cnt(lookup_cnt), .hit_cnt(hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: each set is a small table of entries; a flush is
  // modelled as an instant wipe plus a busy window of SETS cycles.
  bit          m_v   [SETS][WAYS];
  logic [31:0] m_k   [SETS][WAYS];
  logic [31:0] m_t   [SETS][WAYS];
  int          m_c   [SETS][WAYS];
  int          m_rr  [SETS];
  int          m_busy;
  longint      m_look, m_taken;

  function automatic int set_of(input logic [31:0] k);
    return int'((k >> 2) % SETS);
  endfunction

  task automatic m_wipe();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_v[s][w] = 0;
    end
  endtask

  task automatic m_read(input logic [31:0] k, output bit h, output bit v, output logic [31:0] t);
    int s;
    s = set_of(k);
    h = 0; v = 0; t = 0;
    if (m_busy == 0) begin
      for (int w = 0; w < WAYS; w++) begin
        if (m_v[s][w] && m_k[s][w] == k) begin
          h = 1;
          t = m_t[s][w];
          v = (m_c[s][w] >= (CMAX + 1) / 2);
        end
      end
    end
  endtask

  task automatic m_write(input logic [31:0] k, input logic [31:0] t, input bit taken);
    int s, way;
    s = set_of(k);
    way = -1;
    for (int w = 0; w < WAYS; w++) if (m_v[s][w] && m_k[s][w] == k) way = w;
    if (way >= 0) begin
      m_t[s][way] = t;
      if (taken) m_c[s][way] = (m_c[s][way] < CMAX) ? m_c[s][way] + 1 : CMAX;
      else       m_c[s][way] = (m_c[s][way] > 0) ? m_c[s][way] - 1 : 0;
    end else begin
      for (int w = WAYS - 1; w >= 0; w--) if (!m_v[s][w]) way = w;
      if (way < 0) begin
        way = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % WAYS;
      end
      m_v[s][way] = 1;
      m_k[s][way] = k;
      m_t[s][way] = t;
      m_c[s][way] = taken ? CMAX : 0;
    end
  endtask

  task automatic m_step();
    bit h, v;
    logic [31:0] t;
    if (reset) begin
      m_wipe();
      m_busy = 0; m_look = 0; m_taken = 0;
    end else if (m_busy > 0) begin
      m_busy--;
    end else if (flush) begin
      m_wipe();
      m_busy = SETS; m_look = 0; m_taken = 0;
    end else begin
      if (read_en) begin
        m_read(read_key, h, v, t);
        if (m_look < SAT32) m_look++;
        if (v && m_taken < SAT32) m_taken++;
      end
      if (write) m_write(write_key, write_val, hit);
    end
  endtask

  // Compare all outputs against the model, then advance one clock.
  task automatic tick();
    bit h, v;
    logic [31:0] t;
    longint el, eh;
    #3;
    m_read(read_key, h, v, t);
`ifdef BTB_STATS_EN
    el = m_look; eh = m_taken;
`else
    el = 0; eh = 0;
`endif
    check_val("rd_hit", read_hit, h);
    check_val("rd_valid", read_valid, v);
    check_val("rd_val", read_val, t);
    check_val("busy", busy, m_busy > 0);
    check_val("lookup_cnt", lookup_cnt, el);
    check_val("hit_cnt", hit_cnt, eh);
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1; tick(); tick(); reset = 0;
  endtask

  task automatic wr(input logic [31:0] k, input logic [31:0] t, input bit taken);
    write = 1; write_key = k; write_val = t; hit = taken;
    tick();
    write = 0;
  endtask

  task automatic probe(input string tag, input logic [31:0] k, input bit eh, input bit ev, input logic [31:0] et);
    read_key = k;
    #1;
    check_val({tag, "_hit"}, read_hit, eh);
    check_val({tag, "_valid"}, read_valid, ev);
    check_val({tag, "_val"}, read_val, et);
  endtask

  int busy_n;
  logic [31:0] rk;

  initial begin
    reset = 1; read_en = 0; read_key = 0; write = 0; write_key = 0;
    write_val = 0; hit = 0; flush = 0;
    m_wipe(); m_busy = 0; m_look = 0; m_taken = 0;
    @(posedge clk); #1;
    do_reset();

    // Reset state
    probe("rst", 32'h40, 0, 0, 32'h0);
    check_val("rst_busy", busy, 0);
    tick();

    // Allocate taken, then weaken twice
    read_key = 32'h100;
    wr(32'h100, 32'h200, 1);
    probe("alloc", 32'h100, 1, 1, 32'h200);
    wr(32'h100, 32'h200, 0);
    probe("dec1", 32'h100, 1, 1, 32'h200);
    wr(32'h100, 32'h200, 0);
    probe("dec2", 32'h100, 1, 0, 32'h200);

    // Eviction in set 0
    do_reset();
    wr(32'h100, 32'h11, 1);
    wr(32'h140, 32'h22, 1);
    wr(32'h180, 32'h33, 1);
    probe("evict_a", 32'h100, 0, 0, 32'h0);
    probe("evict_b", 32'h140, 1, 1, 32'h22);
    probe("evict_c", 32'h180, 1, 1, 32'h33);
    tick();

    // Flush with a write arriving one cycle later
    flush = 1; tick(); flush = 0;
    write = 1; write_key = 32'h300; write_val = 32'h55; hit = 1;
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      busy_n++;
      tick();
      write = 0;
    end
    write = 0;
    check_val("busy_len", busy_n, SETS);
    probe("fl_300", 32'h300, 0, 0, 32'h0);
    probe("fl_140", 32'h140, 0, 0, 32'h0);
    probe("fl_180", 32'h180, 0, 0, 32'h0);
    tick();

    // Statistics: 5 lookups, 2 predicted taken
    do_reset();
    wr(32'h100, 32'hA0, 1);
    wr(32'h104, 32'hA4, 0);
    read_en = 1;
    read_key = 32'h100; tick();
    read_key = 32'h104; tick();
    read_key = 32'h108; tick();
    read_key = 32'h100; tick();
    read_key = 32'h40;  tick();
    read_en = 0;
    #1;
`ifdef BTB_STATS_EN
    check_val("stat_look", lookup_cnt, 5);
    check_val("stat_hit", hit_cnt, 2);
`else
    check_val("stat_look", lookup_cnt, 0);
    check_val("stat_hit", hit_cnt, 0);
`endif
    tick();

    // Randomized traffic over a few sets with frequent key collisions
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 499) == 0);
      flush   = ($urandom_range(0, 99) == 0);
      read_en = $urandom_range(0, 1);
      write   = $urandom_range(0, 1);
      hit     = $urandom_range(0, 1);
      rk = ($urandom_range(0, 7) << 6) | ($urandom_range(0, 3) << 2);
      if ($urandom_range(0, 15) == 0) rk = rk | $urandom_range(0, 3);
      read_key  = rk;
      write_key = ($urandom_range(0, 7) << 6) | ($urandom_range(0, 3) << 2);
      if ($urandom_range(0, 3) == 0) write_key = read_key;
      write_val = $urandom;
      tick();
    end
    reset = 0; flush = 0; write = 0; read_en = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
